incr_share_sched: RTL

//   Shares one CHUNK-bit incrementer slice between NREQ requesters.
//   - Each requester submits a WIDTH-bit operand and receives operand+1, its requester id and a carry-out.
//   - Requesters are granted round-robin.
//   - Each operand is processed LSB-first, one CHUNK-bit slice per cycle, with the carry chained between slices.
//   - Sits between the testbench-facing input ports and the add-one datapath, replacing per-width adders with one time-shared unit.

---
 rtl/incr_share_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/incr_share_sched.sv
// incr_share_sched
//   Time-shares one CHUNK-bit add-one slice between NREQ requesters.
//   A round-robin arbiter grants one requester in IDLE. Its operand is then
//   incremented LSB-first, one slice per cycle, with the carry chained
//   between slices. The result is held in RESP until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester operand pending
//   req_ready  one-hot grant (operand accepted on this edge)
//   req_data   operand i at bits [i*WIDTH +: WIDTH]
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_data   operand + 1, modulo 2^WIDTH
//   rsp_id     requester that owns the result
//   rsp_carry  carry out of bit WIDTH-1
//   busy       high in CALC or RESP
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; latch the granted operand and start at beat 0
// CALC  | add carry into one slice per cycle, exactly NBEATS cycles
// RESP  | hold result with rsp_valid until rsp_ready
module incr_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 70,
  parameter int CHUNK = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_carry,
  output logic                    busy
);

  localparam int NBEATS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NBEATS * CHUNK;
  localparam int LASTW  = WIDTH - (NBEATS - 1) * CHUNK;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  // Bits of the final slice that belong to the operand; the rest is padding.
  localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LASTW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     op_q, op_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_carry_q, rsp_carry_d;

  logic [NREQ-1:0]   grant_vec;
  logic [IDW-1:0]    grant_id;
  logic              grant_found;

  logic [CHUNK:0]    sum;
  logic              is_last;
  logic [CHUNK-1:0]  slice_res;
  logic              slice_cout;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_vec   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_id    = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
    if (grant_found) begin
      grant_vec = NREQ'(1) << grant_id;
    end
  end

  // The operand register rotates right by one slice per beat, so the active
  // slice is always at the bottom and the result is back in place after
  // NBEATS beats. The final slice carries zero padding above LASTW, so its
  // carry-out is taken from bit LASTW and the padding is kept clear.
  always_comb begin
    sum        = {1'b0, op_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    is_last    = (beat_q == BW'(NBEATS - 1));
    slice_res  = is_last ? (sum[CHUNK-1:0] & LAST_MASK) : sum[CHUNK-1:0];
    slice_cout = is_last ? sum[LASTW] : sum[CHUNK];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    beat_d      = beat_q;
    carry_d     = carry_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_d    = PW'(req_data[int'(grant_id)*WIDTH +: WIDTH]);
          id_d    = grant_id;
          beat_d  = '0;
          carry_d = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        op_d    = (op_q >> CHUNK) | (PW'(slice_res) << (PW - CHUNK));
        carry_d = slice_cout;
        beat_d  = beat_q + BW'(1);
        if (is_last) begin
          rsp_data_d  = op_d[WIDTH-1:0];
          rsp_id_d    = id_q;
          rsp_carry_d = slice_cout;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      op_q        <= '0;
      id_q        <= '0;
      beat_q      <= '0;
      carry_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      beat_q      <= beat_d;
      carry_q     <= carry_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  // Grant is combinational from req_valid; suppressed while reset is high
  // since nothing is accepted on a reset edge.
  assign req_ready = (state_q == IDLE && !reset) ? grant_vec : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_carry = rsp_carry_q;

endmodule
